// File: rtl/multicycle_step_controller.sv
// Step sequencer for the multicycle RISC core: owns the step counter, latches the
// opcode fields during decode and issues the per-step datapath strobes.
module multicycle_step_controller #(
  parameter int MAX_STEP = 4
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic [4:0] InsM,
  input  logic [2:0] InsC,
  input  logic [1:0] InsL,
  input  logic       Flag_C,
  input  logic       Flag_Z,
  output logic [2:0] Cnt,
  output logic       IR_Load,
  output logic       PC_Inc,
  output logic       Buff_PC,
  output logic       PC_Load,
  output logic       Reg_Write,
  output logic       Mem_Read,
  output logic       Mem_Write,
  output logic       Flag_Write,
  output logic       Out_En,
  output logic       Halt,
  output logic       Illegal
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  localparam logic [3:0] CL_RW2 = 4'd0;
  localparam logic [3:0] CL_ALU = 4'd1;
  localparam logic [3:0] CL_CMP = 4'd2;
  localparam logic [3:0] CL_LDR = 4'd3;
  localparam logic [3:0] CL_STR = 4'd4;
  localparam logic [3:0] CL_BCC = 4'd5;
  localparam logic [3:0] CL_JMP = 4'd6;
  localparam logic [3:0] CL_JAL = 4'd7;
  localparam logic [3:0] CL_OUT = 4'd8;
  localparam logic [3:0] CL_HLT = 4'd9;
  localparam logic [3:0] CL_ILL = 4'd10;

  localparam logic [2:0] WD_STEP = 3'(MAX_STEP);

  // No encoding is a true NOP; the reset value is always overwritten at Cnt==1 before use.
  localparam logic [4:0] NOP_M = 5'b00000;
  localparam logic [2:0] NOP_C = 3'b000;
  localparam logic [1:0] NOP_L = 2'b00;

  logic [2:0] cnt_q, cnt_d;
  logic [0:0] state_q, state_d;
  logic [4:0] op_m_q, op_m_d;
  logic [2:0] op_c_q, op_c_d;
  logic [1:0] op_l_q, op_l_d;

  logic [3:0] cls_s;
  logic [2:0] last_s;
  logic       taken_s;
  logic       halt_entry_s;
  logic       ir_s, pci_s, buff_s, pcl_s, rw_s, mr_s, mw_s, fw_s, oe_s, ill_s;

  // Instruction class from the latched opcode fields
  always_comb begin
    cls_s = CL_ILL;
    case (op_m_q)
      5'b00001, 5'b00010, 5'b01011: cls_s = CL_RW2;
      5'b00000, 5'b00111, 5'b01000: cls_s = CL_ALU;
      5'b00011:                     cls_s = CL_LDR;
      5'b00100:                     cls_s = (op_l_q == 2'b00) ? CL_LDR : CL_ILL;
      5'b00101:                     cls_s = CL_STR;
      5'b00110: begin
        if (op_l_q == 2'b00) begin
          cls_s = CL_STR;
        end else if (op_l_q == 2'b01) begin
          cls_s = CL_CMP;
        end else begin
          cls_s = CL_ILL;
        end
      end
      5'b11000:                     cls_s = (op_c_q[2] == 1'b0) ? CL_BCC : CL_ILL;
      5'b11001:                     cls_s = (op_c_q == 3'b110) ? CL_JMP : CL_ILL;
      5'b10000, 5'b10011:           cls_s = CL_JMP;
      5'b10001, 5'b10010:           cls_s = CL_JAL;
      5'b11100: begin
        if (op_l_q == 2'b00) begin
          cls_s = CL_OUT;
        end else if (op_l_q == 2'b01) begin
          cls_s = CL_HLT;
        end else begin
          cls_s = CL_ILL;
        end
      end
      default:                      cls_s = CL_ILL;
    endcase
  end

  // Branch condition evaluated against the live flags during step 2
  always_comb begin
    case (op_c_q)
      3'b011:  taken_s = ~Flag_C;
      3'b010:  taken_s = Flag_C;
      3'b001:  taken_s = Flag_Z;
      3'b000:  taken_s = ~Flag_Z;
      default: taken_s = 1'b0;
    endcase
  end

  // Per-step strobes before reset gating
  always_comb begin
    ir_s   = 1'b0;
    pci_s  = 1'b0;
    buff_s = 1'b0;
    pcl_s  = 1'b0;
    rw_s   = 1'b0;
    mr_s   = 1'b0;
    mw_s   = 1'b0;
    fw_s   = 1'b0;
    oe_s   = 1'b0;
    ill_s  = 1'b0;
    case (cls_s)
      CL_ALU, CL_STR, CL_JAL: last_s = 3'd3;
      CL_LDR:                 last_s = 3'd4;
      default:                last_s = 3'd2;
    endcase
    if (state_q == ST_RUN && cnt_q == 3'd0) begin
      ir_s  = 1'b1;
      pci_s = 1'b1;
    end else if (state_q == ST_RUN && cnt_q >= 3'd2) begin
      case (cls_s)
        CL_RW2: rw_s = (cnt_q == 3'd2);
        CL_ALU: begin
          fw_s = (cnt_q == 3'd2);
          rw_s = (cnt_q == 3'd3);
        end
        CL_CMP: fw_s = (cnt_q == 3'd2);
        CL_LDR: begin
          mr_s = (cnt_q == 3'd3);
          rw_s = (cnt_q == 3'd4);
        end
        CL_STR: mw_s  = (cnt_q == 3'd3);
        CL_BCC: pcl_s = (cnt_q == 3'd2) && taken_s;
        CL_JMP: pcl_s = (cnt_q == 3'd2);
        CL_JAL: begin
          rw_s  = (cnt_q == 3'd2);
          pcl_s = (cnt_q == 3'd3);
        end
        CL_OUT: oe_s  = (cnt_q == 3'd2);
        CL_ILL: ill_s = (cnt_q == 3'd2);
        default: ill_s = 1'b0;
      endcase
      buff_s = (cls_s != CL_HLT) && (cnt_q == last_s);
      // Watchdog: a runaway step count closes the instruction and flags it
      if (!buff_s && cls_s != CL_HLT && cnt_q >= WD_STEP) begin
        buff_s = 1'b1;
        ill_s  = 1'b1;
      end else begin
        ill_s  = ill_s;
      end
    end else begin
      ir_s = 1'b0;
    end
  end

  assign halt_entry_s = (state_q == ST_RUN) && (cnt_q == 3'd2) && (cls_s == CL_HLT);

  // Step counter, run/halt state and opcode latch next-state
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    op_m_d  = op_m_q;
    op_c_d  = op_c_q;
    op_l_d  = op_l_q;
    if (state_q == ST_HALT) begin
      cnt_d = cnt_q;
    end else if (halt_entry_s) begin
      state_d = ST_HALT;
    end else if (buff_s) begin
      cnt_d = 3'd0;
    end else begin
      cnt_d = cnt_q + 3'd1;
    end
    if (state_q == ST_RUN && cnt_q == 3'd1) begin
      op_m_d = InsM;
      op_c_d = InsC;
      op_l_d = InsL;
    end else begin
      op_m_d = op_m_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (Rst) begin
      cnt_q   <= 3'd0;
      state_q <= ST_RUN;
      op_m_q  <= NOP_M;
      op_c_q  <= NOP_C;
      op_l_q  <= NOP_L;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      op_m_q  <= op_m_d;
      op_c_q  <= op_c_d;
      op_l_q  <= op_l_d;
    end
  end

  assign Cnt        = cnt_q;
  assign IR_Load    = ir_s   & ~Rst;
  assign PC_Inc     = pci_s  & ~Rst;
  assign Buff_PC    = buff_s & ~Rst;
  assign PC_Load    = pcl_s  & ~Rst;
  assign Reg_Write  = rw_s   & ~Rst;
  assign Mem_Read   = mr_s   & ~Rst;
  assign Mem_Write  = mw_s   & ~Rst;
  assign Flag_Write = fw_s   & ~Rst;
  assign Out_En     = oe_s   & ~Rst;
  assign Halt       = (state_q == ST_HALT) & ~Rst;
  assign Illegal    = ill_s  & ~Rst;

endmodule

// File: tb/tb_multicycle_step_controller.sv
// Randomized bench for multicycle_step_controller against an instruction-level
// reference model describing which step each strobe fires on.
module tb_multicycle_step_controller;

  logic       clk = 1'b0;
  logic       Rst;
  logic [4:0] InsM;
  logic [2:0] InsC;
  logic [1:0] InsL;
  logic       Flag_C, Flag_Z;
  logic [2:0] Cnt;
  logic       IR_Load, PC_Inc, Buff_PC, PC_Load, Reg_Write, Mem_Read;
  logic       Mem_Write, Flag_Write, Out_En, Halt, Illegal;
  logic [10:0] obs;

  int check_cnt = 0;
  int fail_cnt  = 0;

  always #5 clk = ~clk;

  multicycle_step_controller #(.MAX_STEP(4)) dut (
    .clk(clk), .Rst(Rst), .InsM(InsM), .InsC(InsC), .InsL(InsL),
    .Flag_C(Flag_C), .Flag_Z(Flag_Z), .Cnt(Cnt), .IR_Load(IR_Load),
    .PC_Inc(PC_Inc), .Buff_PC(Buff_PC), .PC_Load(PC_Load),
    .Reg_Write(Reg_Write), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
    .Flag_Write(Flag_Write), .Out_En(Out_En), .Halt(Halt), .Illegal(Illegal)
  );

  assign obs = {IR_Load, PC_Inc, Buff_PC, PC_Load, Reg_Write, Mem_Read,
                Mem_Write, Flag_Write, Out_En, Halt, Illegal};

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Step number (0 = never) at which each strobe fires for one instruction
  typedef struct {
    int last; int rw; int fw; int mr; int mw; int pcl; int oe;
    bit ill; bit hlt;
  } ref_t;

  function automatic ref_t ref_decode(input logic [4:0] m, input logic [2:0] c,
                                      input logic [1:0] l, input logic fc, input logic fz);
    ref_t r;
    r.last = 2; r.rw = 0; r.fw = 0; r.mr = 0; r.mw = 0; r.pcl = 0; r.oe = 0;
    r.ill = 1'b0; r.hlt = 1'b0;
    if (m == 5'd1 || m == 5'd2 || m == 5'd11) r.rw = 2;
    else if (m == 5'd0 || m == 5'd7 || m == 5'd8) begin r.fw = 2; r.rw = 3; r.last = 3; end
    else if (m == 5'd6 && l == 2'd1) r.fw = 2;
    else if (m == 5'd3 || (m == 5'd4 && l == 2'd0)) begin r.mr = 3; r.rw = 4; r.last = 4; end
    else if (m == 5'd5 || (m == 5'd6 && l == 2'd0)) begin r.mw = 3; r.last = 3; end
    else if (m == 5'd24 && c <= 3'd3) begin
      bit taken;
      taken = (c == 3'd3) ? !fc : (c == 3'd2) ? fc : (c == 3'd1) ? fz : !fz;
      r.pcl = taken ? 2 : 0;
    end
    else if ((m == 5'd25 && c == 3'd6) || m == 5'd16 || m == 5'd19) r.pcl = 2;
    else if (m == 5'd17 || m == 5'd18) begin r.rw = 2; r.pcl = 3; r.last = 3; end
    else if (m == 5'd28 && l == 2'd0) r.oe = 2;
    else if (m == 5'd28 && l == 2'd1) r.hlt = 1'b1;
    else r.ill = 1'b1;
    return r;
  endfunction

  function automatic logic [10:0] ref_strobes(input ref_t r, input int s);
    logic [10:0] v;
    v = {s == 0, s == 0, !r.hlt && s == r.last,
         r.pcl != 0 && r.pcl == s, r.rw != 0 && r.rw == s,
         r.mr != 0 && r.mr == s, r.mw != 0 && r.mw == s,
         r.fw != 0 && r.fw == s, r.oe != 0 && r.oe == s,
         1'b0, r.ill && s == 2};
    return v;
  endfunction

  // Entered at posedge+1 with Cnt==0; abort_at asserts Rst during that step
  task automatic run_instr(input logic [4:0] m, input logic [2:0] c, input logic [1:0] l,
                           input logic fc, input logic fz, input int abort_at, input string tag);
    ref_t r;
    int buffs;
    r = ref_decode(m, c, l, fc, fz);
    buffs = 0;
    for (int s = 0; s <= r.last; s++) begin
      if (s == 1) begin
        InsM = m; InsC = c; InsL = l;
      end else begin
        InsM = 5'($urandom); InsC = 3'($urandom); InsL = 2'($urandom);
      end
      if (s == 2) begin
        Flag_C = fc; Flag_Z = fz;
      end else begin
        Flag_C = 1'($urandom); Flag_Z = 1'($urandom);
      end
      if (s == abort_at) Rst = 1'b1;
      #4;
      check_value({tag, "_cnt"}, 32'(Cnt), 32'(s));
      if (s == abort_at) begin
        check_value({tag, "_rst_strb"}, 32'(obs), 32'd0);
        @(posedge clk); #1;
        check_value({tag, "_rst_cnt"}, 32'(Cnt), 32'd0);
        check_value({tag, "_rst_halt"}, 32'(Halt), 32'd0);
        Rst = 1'b0;
        return;
      end
      check_value({tag, "_strb"}, 32'(obs), 32'(ref_strobes(r, s)));
      buffs += int'(Buff_PC);
      @(posedge clk); #1;
    end
    check_value({tag, "_buffs"}, 32'(buffs), r.hlt ? 32'd0 : 32'd1);
    if (r.hlt) begin
      for (int k = 0; k < 12; k++) begin
        InsM = 5'($urandom); InsL = 2'($urandom);
        Flag_C = 1'($urandom); Flag_Z = 1'($urandom);
        #4;
        check_value({tag, "_halt_cnt"}, 32'(Cnt), 32'd2);
        check_value({tag, "_halt_strb"}, 32'(obs), 32'h2);
        @(posedge clk); #1;
      end
      Rst = 1'b1;
      #4;
      check_value({tag, "_hrst_strb"}, 32'(obs), 32'd0);
      @(posedge clk); #1;
      check_value({tag, "_hrst_cnt"}, 32'(Cnt), 32'd0);
      Rst = 1'b0;
    end
  endtask

  initial begin
    Rst = 1'b1; InsM = 5'd0; InsC = 3'd0; InsL = 2'd0; Flag_C = 1'b0; Flag_Z = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_value("reset_cnt", 32'(Cnt), 32'd0);
    check_value("reset_strb", 32'(obs), 32'd0);
    Rst = 1'b0;

    run_instr(5'b00000, 3'd0, 2'b00, 1'b0, 1'b0, -1, "add");
    run_instr(5'b00100, 3'd0, 2'b00, 1'b0, 1'b0, -1, "ldrrr");
    run_instr(5'b00101, 3'd0, 2'b00, 1'b0, 1'b0, -1, "strri");
    run_instr(5'b11000, 3'b001, 2'b00, 1'b0, 1'b1, -1, "beq_t");
    run_instr(5'b11000, 3'b001, 2'b00, 1'b1, 1'b0, -1, "beq_n");
    run_instr(5'b11000, 3'b011, 2'b00, 1'b0, 1'b1, -1, "bcc_t");
    run_instr(5'b11000, 3'b011, 2'b00, 1'b1, 1'b0, -1, "bcc_n");
    run_instr(5'b10010, 3'd0, 2'b00, 1'b0, 1'b0, -1, "jalrr");
    run_instr(5'b11111, 3'd0, 2'b00, 1'b0, 1'b0, -1, "undef");
    run_instr(5'b00110, 3'd0, 2'b10, 1'b0, 1'b0, -1, "undef6");
    run_instr(5'b00011, 3'd0, 2'b00, 1'b0, 1'b0, 3, "ldr_abort");
    run_instr(5'b00001, 3'd0, 2'b00, 1'b0, 1'b0, -1, "lhi_after");
    run_instr(5'b11100, 3'd0, 2'b01, 1'b0, 1'b0, -1, "hlt");

    for (int m = 1; m <= 25; m++) begin
      run_instr(5'(m), 3'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), -1, "sweep");
    end

    for (int n = 0; n < 250; n++) begin
      int ab;
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(5'($urandom), 3'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), ab, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/multicycle_step_controller.md
Name: multicycle_step_controller

Overview:
- Main sequencer for the multicycle RISC core.
- Owns the step counter Cnt and decodes the opcode fields captured at Cnt==1.
- Produces the per-step datapath strobes, including Buff_PC, which closes each instruction.
- Replaces the free-running bench counter; feeds the PC/IR registers, register file, memory port, flag register and output port.

Parameters:
- MAX_STEP, 4, highest legal Cnt value; watchdog bound.

Ports:
- clk  in  1  system clock, rising edge.
- Rst  in  1  synchronous, active-high reset.
- InsM  in  5  instruction bits [15:11], the major opcode.
- InsC  in  3  instruction bits [10:8], the branch condition.
- InsL  in  2  instruction bits [1:0], the minor opcode.
- Flag_C  in  1  registered carry flag.
- Flag_Z  in  1  registered zero flag.
- Cnt  out  3  current step.
- IR_Load  out  1  load instruction register.
- PC_Inc  out  1  PC <= PC+1.
- Buff_PC  out  1  last step of the instruction; Cnt returns to 0 next edge.
- PC_Load  out  1  load PC from ALU/register target.
- Reg_Write  out  1  register-file write.
- Mem_Read  out  1  data-memory read.
- Mem_Write  out  1  data-memory write.
- Flag_Write  out  1  update C/Z flags.
- Out_En  out  1  latch the output port.
- Halt  out  1  core halted.
- Illegal  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- Reset:
  - On Rst at a clk edge: Cnt=0, state=RUN, latched opcode=NOP, Halt=0.
  - While Rst=1, every strobe is forced 0 combinationally.
  - Reset mid-instruction aborts it with no further strobes.
- Outputs are combinational from the registered Cnt, state and latched opcode.
- Cnt==0 (fetch): IR_Load=1, PC_Inc=1.
- Cnt==1 (decode):
  - No strobes.
  - {InsM, InsC, InsL} is latched at the edge ending this step.
  - InsM/InsL are don't-care outside Cnt==1.
- Cnt advances +1 per clock. After a step with Buff_PC=1, Cnt goes to 0.
- Per-class steps (last step carries Buff_PC):
  - LHI 00001, LLI 00010, MOV 01011: Reg_Write@2; last=2.
  - ADD/ADC/SUB/SBB (00000, InsL 00/01/10/11), ADDI 00111, SUBI 01000: Flag_Write@2, Reg_Write@3; last=3.
  - CMP (00110, InsL=01): Flag_Write@2; last=2.
  - LDRri 00011, LDRrr (00100, InsL=00): Mem_Read@3, Reg_Write@4; last=4.
  - STRri 00101, STRrr (00110, InsL=00): Mem_Write@3; last=3.
  - 00110 with InsL 10 or 11 is undefined.
  - Bcc (11000): PC_Load@2 if taken, using flags sampled in step 2; last=2.
    - InsC 011 BCC: taken if C=0.
    - InsC 010 BCS: taken if C=1.
    - InsC 001 BEQ: taken if Z=1.
    - InsC 000 BNE: taken if Z=0.
    - Other InsC values: undefined.
  - BAL (11001, InsC=110): PC_Load@2 unconditionally; last=2.
  - JMP 10000, JR 10011: PC_Load@2; last=2.
  - JALrl 10001, JALrr 10010: Reg_Write@2 (link), PC_Load@3; last=3.
  - OutR (11100, InsL=00): Out_En@2; last=2.
  - HLT (11100, InsL=01):
    - At Cnt==2, enter HALT and assert Halt=1 from the next cycle.
    - No Buff_PC is issued.
    - Cnt freezes at 2 and all strobes stay 0.
    - Only Rst exits HALT.
- Undefined opcode: Illegal=1 and Buff_PC=1 at Cnt==2, no other strobes; executes as a NOP.
- Watchdog: if Cnt reaches MAX_STEP without Buff_PC (cannot occur for legal decode), force Buff_PC=1 and pulse Illegal.
- Rst and Buff_PC in the same cycle: Rst wins (Cnt=0, strobes 0).

Test Plan:
- Rst for 2 cycles, release, then issue ADD (InsM=00000, InsL=00) -> Cnt 0,1,2,3,0. IR_Load/PC_Inc@0, Flag_Write@2, Reg_Write@3, Buff_PC@3 only.
- Issue LDRrr (00100/00) then STRri (00101) -> Buff_PC at Cnt 4 then at Cnt 3. Mem_Read@3 with Reg_Write@4, then Mem_Write@3. Mem strobes never overlap.
- BEQ (11000, InsC 001):
  - Z=1 -> PC_Load=1@2 with Buff_PC@2.
  - Z=0 -> PC_Load=0, still Buff_PC@2.
- BCC (InsC 011) with C=0/1 gives the analogous taken/not-taken result.
- JALrr (10010) -> Reg_Write@2, PC_Load@3, Buff_PC@3.
- Undefined InsM=11111 -> Illegal=1 and Buff_PC=1 at Cnt==2.
- HLT (11100/01) -> Halt=1 from the cycle after Cnt==2, Cnt held at 2, no Buff_PC for ≥10 cycles.
- Rst mid-LDR at Cnt==3 -> all strobes 0 that cycle, Cnt=0 next edge, Halt=0, Buff_PC=0.
- Full sweep of opcodes 0x01–0x19 back-to-back, as in the existing bench encodings -> Buff_PC exactly once per instruction.
